// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer.
//   state_t                  - debouncer FSM state encoding (STABLE=0, SETTLING=1)
//   DEBOUNCE_CYCLES_DEFAULT  - default number of consecutive stable cycles to accept a value
package sw_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/sw_debounce_sync_2ff.sv
// Two-flop synchronizer for a vector of asynchronous inputs.
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both stages
//   d_i  - raw asynchronous inputs (WIDTH bits)
//   q_o  - synchronized outputs, two clk edges behind d_i
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sw_debounce.sv
// Whole-vector debouncer for an enable switch plus WIDTH slide switches.
// The synchronized vector S = {en_i, sw_i} must hold one new value for DEBOUNCE_CYCLES
// consecutive cycles before the registered output D = {en_o, sw_o} takes it.
//   clk       - clock, all state on the rising edge
//   rst       - asynchronous active-high reset
//   en_i      - raw enable switch (asynchronous)
//   sw_i      - raw switch vector (asynchronous)
//   en_o      - debounced enable (flop output)
//   sw_o      - debounced switch vector (flop output)
//   change_o  - one-cycle pulse in the first cycle a new en_o/sw_o is visible
//   busy_o    - high while a candidate value is settling
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] sw_i,
    output logic             en_o,
    output logic [WIDTH-1:0] sw_o,
    output logic             change_o,
    output logic             busy_o
);

    localparam int unsigned VW = WIDTH + 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [VW-1:0] s;
    logic [VW-1:0] d_q, d_d;
    logic [VW-1:0] c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic          change_q, change_d;

    sync_2ff #(
        .WIDTH (VW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({en_i, sw_i}),
        .q_o (s)
    );

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        change_d = 1'b0;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s != d_q) begin
                    c_d     = s;
                    cnt_d   = CW'(1);
                    state_d = SETTLING;
                end
            end
            SETTLING: begin
                // c_q never equals d_q here, so the bounce-back test can go first.
                if (s == d_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (s == c_q) begin
                    if (cnt_q == CNT_LAST) begin
                        d_d      = c_q;
                        cnt_d    = '0;
                        change_d = 1'b1;
                        state_d  = STABLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // New target: restart the settle window from this value.
                    c_d   = s;
                    cnt_d = CW'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= STABLE;
            d_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
        end
    end

    assign en_o     = d_q[WIDTH];
    assign sw_o     = d_q[WIDTH-1:0];
    assign change_o = change_q;
    assign busy_o   = (state_q == SETTLING);

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

    localparam int unsigned W  = 8;
    localparam int unsigned DC = 4;

    logic         clk;
    logic         rst;
    logic         en_i;
    logic [W-1:0] sw_i;
    logic         en_o;
    logic [W-1:0] sw_o;
    logic         change_o;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;

    sw_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .sw_i     (sw_i),
        .en_o     (en_o),
        .sw_o     (sw_o),
        .change_o (change_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw input is delayed two edges, then an output update happens when the
    // trailing run of identical synchronized values (all differing from D) reaches DC edges.
    logic [W:0] m_s1, m_s2, m_d, m_run_val;
    int         m_run_len;
    logic       m_busy, m_change;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        m_s1 = '0; m_s2 = '0; m_d = '0; m_run_val = '0; m_run_len = 0;
        m_busy = 1'b0; m_change = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".en_o"},     32'(en_o),     32'(m_d[W]));
        chk({tag, ".sw_o"},     32'(sw_o),     32'(m_d[W-1:0]));
        chk({tag, ".change_o"}, 32'(change_o), 32'(m_change));
        chk({tag, ".busy_o"},   32'(busy_o),   32'(m_busy));
    endtask

    // One clock edge: advance the model, then sample the DUT 1 time unit later.
    task automatic step(input string tag);
        logic [W:0] s;
        @(posedge clk);
        if (!rst) begin
            s = m_s2;
            if (s == m_run_val) m_run_len++;
            else begin
                m_run_val = s;
                m_run_len = 1;
            end
            if (s != m_d && m_run_len >= int'(DC)) begin
                m_d      = s;
                m_change = 1'b1;
                m_busy   = 1'b0;
            end else begin
                m_change = 1'b0;
                m_busy   = (s != m_d);
            end
            m_s2 = m_s1;
            m_s1 = {en_i, sw_i};
        end
        #1;
        check_outputs(tag);
    endtask

    // Edges until change_o is seen, counting the first edge as 1; 0 if none within budget.
    task automatic edges_to_change(input string tag, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step(tag);
            if (change_o) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        mreset();
        check_outputs(tag);
    endtask

    initial begin
        int n;
        int pulses;
        int seen10;
        int busy_drop;
        int busy_hi;
        int r;

        rst = 1'b0; en_i = 1'b0; sw_i = '0;
        mreset();
        #2;

        // Reset, then all-zero inputs: outputs stay at zero.
        async_reset("reset");
        for (int i = 0; i < 3; i++) step("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step("idle");

        // Clean change: first sampling edge is edge 1, update on edge 6 with one pulse.
        en_i = 1'b1; sw_i = 8'h24;
        edges_to_change("clean", n);
        chk("clean_latency", 32'(n), 32'd6);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step("clean_after");
            pulses += int'(change_o);
        end
        chk("clean_extra_pulses", 32'(pulses), 32'd0);
        chk("clean_sw", 32'(sw_o), 32'h24);
        chk("clean_en", 32'(en_o), 32'd1);

        // Bounce: 0x00/0x01 every 2 cycles for 20 cycles, then settle at 0x01.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            sw_i = ((i / 2) % 2 == 1) ? 8'h01 : 8'h00;
            step("bounce");
            pulses += int'(change_o);
        end
        chk("bounce_no_pulse", 32'(pulses), 32'd0);
        chk("bounce_held", 32'(sw_o), 32'h24);
        sw_i = 8'h01;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step("bounce_settle");
            pulses += int'(change_o);
        end
        chk("bounce_pulses", 32'(pulses), 32'd1);
        chk("bounce_final", 32'(sw_o), 32'h01);

        // Retarget: 0x10 briefly, then 0x80 held.
        seen10 = 0; busy_drop = 0; busy_hi = 0; pulses = 0;
        sw_i = 8'h10;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) sw_i = 8'h80;
            step("retarget");
            if (sw_o == 8'h10) seen10++;
            if (busy_hi != 0 && !busy_o && pulses == 0 && !change_o) busy_drop++;
            if (busy_o) busy_hi = 1;
            pulses += int'(change_o);
        end
        chk("retarget_no_0x10", 32'(seen10), 32'd0);
        chk("retarget_busy_held", 32'(busy_drop), 32'd0);
        chk("retarget_pulses", 32'(pulses), 32'd1);
        chk("retarget_final", 32'(sw_o), 32'h80);

        // Async reset two cycles into SETTLING, between clock edges.
        sw_i = 8'hFF;
        n = 0;
        for (int i = 0; i < 10 && !busy_o; i++) step("settle_wait");
        chk("settle_entered", 32'(busy_o), 32'd1);
        step("settle_1");
        step("settle_2");
        #2;
        async_reset("midreset");
        chk("midreset_sw", 32'(sw_o), 32'h00);
        chk("midreset_en", 32'(en_o), 32'd0);
        step("midreset_hold");
        rst = 1'b0;
        edges_to_change("post_reset", n);
        chk("post_reset_latency", 32'(n), 32'd6);
        chk("post_reset_sw", 32'(sw_o), 32'hFF);

        // Glitch: 0x03 for one cycle, then back to the accepted value.
        for (int i = 0; i < 4; i++) step("glitch_pre");
        pulses = 0; busy_hi = 0;
        sw_i = 8'h03;
        step("glitch");
        sw_i = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step("glitch_after");
            pulses  += int'(change_o);
            busy_hi += int'(busy_o);
        end
        chk("glitch_no_pulse", 32'(pulses), 32'd0);
        chk("glitch_busy_brief", 32'(busy_hi <= 1), 32'd1);
        chk("glitch_sw", 32'(sw_o), 32'hFF);

        // Randomized run against the model, with one mid-cycle reset.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                en_i = 1'($urandom);
                sw_i = 8'($urandom);
            end else if (r == 2) begin
                sw_i[0] = ~sw_i[0];
            end
            if (i == 200) begin
                #3;
                async_reset("rand_reset");
                step("rand_reset_hold");
                rst = 1'b0;
            end
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 8: number of switch bits debounced.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a new value; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 en_i  input  1  raw enable switch; asynchronous to clk.
REQ-006 sw_i  input  WIDTH  raw slide switches; asynchronous to clk.
REQ-007 en_o  output  1  debounced enable; feeds the encoder/display stage.
REQ-008 sw_o  output  WIDTH  debounced switch vector; feeds the encoder/display stage.
REQ-009 change_o  output  1  one-cycle pulse; asserted in the first cycle new en_o/sw_o values are visible.
REQ-010 busy_o  output  1  high while in SETTLING.

Function
REQ-011 {en_i, sw_i} shall pass through a 2-flop synchronizer per bit; the synchronized vector is called S (WIDTH+1 bits).
REQ-012 The debounced vector D = {en_o, sw_o} shall be a register; the debounce decision covers the whole vector, not individual bits.
REQ-013 FSM states: STABLE, SETTLING. No other states are reachable.
REQ-014 STABLE, S == D: remain; counter held at 0.
REQ-015 STABLE, S != D: load candidate C <= S, counter <= 1, go to SETTLING.
REQ-016 SETTLING, S == C and counter < DEBOUNCE_CYCLES-1: counter increments by 1.
REQ-017 SETTLING, S == C and counter == DEBOUNCE_CYCLES-1: D <= C, counter <= 0, go to STABLE; change_o is high in the following cycle only.
REQ-018 SETTLING, S == D (bounce back): go to STABLE, counter <= 0, D unchanged, no change_o.
REQ-019 SETTLING, S != C and S != D: C <= S, counter <= 1, remain in SETTLING.
REQ-020 Latency: after a raw edge held steady, D updates 2 + DEBOUNCE_CYCLES cycles after the first clock edge that samples it, +/-1 cycle for synchronizer metastability.
REQ-021 The counter shall be $clog2(DEBOUNCE_CYCLES) bits wide, never wrap, and never exceed DEBOUNCE_CYCLES-1.
REQ-022 change_o shall never be high for two consecutive cycles; a minimum of DEBOUNCE_CYCLES cycles separates pulses.
REQ-023 busy_o shall be a decode of state == SETTLING (no extra latency).
REQ-024 Outputs en_o and sw_o shall be driven directly from flops, with no combinational path from en_i or sw_i.

Reset
REQ-025 On rst high: synchronizer flops, D, C, and counter go to 0; state goes to STABLE; change_o and busy_o go to 0; this takes effect immediately and is independent of clk.
REQ-026 Reset asserted mid-SETTLING shall abandon the candidate; no change_o is produced on release.
REQ-027 After release, non-zero raw inputs shall be debounced as a normal change from the all-zero D.

Structure
REQ-028 State encodings (STABLE=0, SETTLING=1) and the default DEBOUNCE_CYCLES shall be placed in the shared npc package.
REQ-029 The 2-flop synchronizer shall be a separate sub-module, sync_2ff, parameterized by width; it is instantiated once with width WIDTH+1.
REQ-030 The implementation shall contain no latches, and sw_debounce shall have no sub-modules other than sync_2ff.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8)
REQ-031 Reset check: rst pulse, then inputs held at 0 -> en_o=0, sw_o=0x00, change_o=0, busy_o=0 throughout.
REQ-032 Clean change: en_i=1, sw_i=0x24 held -> sw_o=0x24 and en_o=1 exactly 6 cycles after the sampling edge; change_o high for that one cycle only.
REQ-033 Bounce: sw_i toggles 0x00/0x01 every 2 cycles for 20 cycles, then settles at 0x01 -> no update during toggling; sw_o=0x01 and a single change_o after settling.
REQ-034 Retarget: sw_i=0x10 for 2 cycles, then 0x80 held -> busy_o stays high, candidate restarts, final sw_o=0x80, and 0x10 never appears.
REQ-035 Async reset mid-settle: sw_i=0xFF, rst asserted 2 cycles into SETTLING without a clock edge -> outputs are 0 immediately; after release with 0xFF held, sw_o=0xFF after the full latency.
REQ-036 Glitch return: sw_i pulses 0x03 for 1 cycle then returns to the old D -> busy_o pulses at most briefly; sw_o unchanged; no change_o.
